regression_controller: RTL and testbench

- Sequencing FSM for the linear-regression datapath.
- Drives the sample-memory address, accumulator clears/enables, divider handshake and coefficient loads. It runs the full fit in three passes over N samples: sums/means, then covariance, then per-sample error.
- Sits between the top-level start/ready interface and the regression datapath. The datapath holds memories, accumulators, the divider and the error unit; this block holds no data.

---
 rtl/regression_pkg.sv | 18 +
 rtl/regression_addr_counter.sv | 30 +++
 rtl/regression_controller.sv | 67 ++++++
 tb/tb_regression_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/regression_pkg.sv
// regression_pkg: state encoding and default sizing shared by the regression controller and datapath
package regression_pkg;
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    CLR1 = 4'd1,
    SUM  = 4'd2,
    MEAN = 4'd3,
    CLR2 = 4'd4,
    COV  = 4'd5,
    DIV  = 4'd6,
    COEF = 4'd7,
    ERR  = 4'd8,
    DONE = 4'd9
  } state_t;
  localparam int STATE_COUNT = 10;
  localparam int N_SAMPLES_DEF = 150;
  localparam int ADDR_W_DEF = 8;
endpackage

// File: rtl/regression_addr_counter.sv
// regression_addr_counter: sample address sequencer with terminal flag and one-cycle-delayed data-valid
module regression_addr_counter
  import regression_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              tc,
  output logic              fin,
  output logic              valid
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);
  assign tc = addr == LAST;
  // address stops at the last sample; fin marks that the last address has been issued
  always_ff @(posedge clk)
    if (!rst || clr) begin
      addr  <= '0;
      fin   <= 1'b0;
      valid <= 1'b0;
    end else begin
      if (en && !tc) addr <= addr + 1'b1;
      if (en && tc) fin <= 1'b1;
      valid <= en;
    end
endmodule

// File: rtl/regression_controller.sv
// regression_controller: three-pass sequencing FSM for the linear-regression datapath
module regression_controller
  import regression_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              div_done,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              acc_clr,
  output logic              sum_en,
  output logic              mean_ld,
  output logic              cov_en,
  output logic              div_start,
  output logic              coef_ld,
  output logic              err_valid
);
  state_t state;
  logic div_wait, pass, clr, issue, tc, fin, valid, pass_end;
  assign pass = state inside {SUM, COV, ERR};
  assign clr = state inside {CLR1, CLR2, COEF};
  assign issue = pass && !fin;
  assign pass_end = tc && fin;
  regression_addr_counter #(.N_SAMPLES(N_SAMPLES), .ADDR_W(ADDR_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (issue),
    .addr  (mem_addr),
    .tc    (tc),
    .fin   (fin),
    .valid (valid)
  );
  // state sequencing; div_wait masks div_done during the divider launch cycle
  always_ff @(posedge clk)
    if (!rst) begin
      state    <= IDLE;
      div_wait <= 1'b0;
    end else begin
      div_wait <= state == DIV;
      case (state)
        IDLE:    if (start) state <= CLR1;
        CLR1:    state <= SUM;
        SUM:     if (pass_end) state <= MEAN;
        MEAN:    state <= CLR2;
        CLR2:    state <= COV;
        COV:     if (pass_end) state <= DIV;
        DIV:     if (div_wait && div_done) state <= COEF;
        COEF:    state <= ERR;
        ERR:     if (pass_end) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign ready     = state == IDLE;
  assign acc_clr   = state inside {CLR1, CLR2};
  assign sum_en    = state == SUM && valid;
  assign mean_ld   = state == MEAN;
  assign cov_en    = state == COV && valid;
  assign div_start = state == DIV && !div_wait;
  assign coef_ld   = state == COEF;
  assign err_valid = state == ERR && valid;
endmodule

// File: tb/tb_regression_controller.sv
// tb_regression_controller: randomized directed runs of the regression sequencer against a phase-level trace model
module tb_regression_controller;
  logic clk, rst, start, dd, sel;
  logic a_ready, a_clr, a_sum, a_mean, a_cov, a_divs, a_coef, a_err;
  logic b_ready, b_clr, b_sum, b_mean, b_cov, b_divs, b_coef, b_err;
  logic [7:0] a_addr, b_addr;
  logic [15:0] obs_a, obs_b;
  logic [16:0] exp_q[$];
  int total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regression_controller #(.N_SAMPLES(4), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .div_done(dd & ~sel),
    .ready(a_ready), .mem_addr(a_addr), .acc_clr(a_clr), .sum_en(a_sum), .mean_ld(a_mean),
    .cov_en(a_cov), .div_start(a_divs), .coef_ld(a_coef), .err_valid(a_err)
  );
  regression_controller #(.N_SAMPLES(256), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .div_done(dd & sel),
    .ready(b_ready), .mem_addr(b_addr), .acc_clr(b_clr), .sum_en(b_sum), .mean_ld(b_mean),
    .cov_en(b_cov), .div_start(b_divs), .coef_ld(b_coef), .err_valid(b_err)
  );

  assign obs_a = {a_addr, a_ready, a_clr, a_sum, a_mean, a_cov, a_divs, a_coef, a_err};
  assign obs_b = {b_addr, b_ready, b_clr, b_sum, b_mean, b_cov, b_divs, b_coef, b_err};

  // flag order: ready, acc_clr, sum_en, mean_ld, cov_en, div_start, coef_ld, err_valid
  function automatic logic [16:0] ent(bit chk, int a, logic [7:0] f);
    return {chk, 8'(a), f};
  endfunction

  task automatic cmp(input string tag, input int idx, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s idx=%0d observed=%b expected=%b", tag, idx, got, want);
    end
  endtask

  task automatic pass_trace(input int n, input logic [7:0] f);
    for (int k = 0; k <= n; k++) exp_q.push_back(ent(1, k < n ? k : n - 1, k > 0 ? f : 8'h00));
  endtask

  // expected cycle-by-cycle trace from the edge after start through the first idle cycle
  task automatic build(input int n, input int d);
    exp_q.delete();
    exp_q.push_back(ent(0, 0, 8'b0100_0000));
    pass_trace(n, 8'b0010_0000);
    exp_q.push_back(ent(0, 0, 8'b0001_0000));
    exp_q.push_back(ent(0, 0, 8'b0100_0000));
    pass_trace(n, 8'b0000_1000);
    for (int k = 0; k <= d; k++) exp_q.push_back(ent(0, 0, k == 0 ? 8'b0000_0100 : 8'h00));
    exp_q.push_back(ent(0, 0, 8'b0000_0010));
    pass_trace(n, 8'b0000_0001);
    exp_q.push_back(ent(0, 0, 8'h00));
    exp_q.push_back(ent(0, 0, 8'b1000_0000));
  endtask

  // called at a negedge while the selected DUT is idle; abort_at >= 0 pulses reset at that trace index
  task automatic run(input bit s, input int d, input int hold, input int abort_at);
    int n;
    int jdiv;
    logic [15:0] got;
    n = s ? 256 : 4;
    jdiv = 2 * n + 5;
    sel = s;
    build(n, d);
    start = 1'b1;
    dd = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = s ? obs_b : obs_a;
      cmp("flags", i, got[7:0], exp_q[i][7:0]);
      if (exp_q[i][16]) cmp("mem_addr", i, got[15:8], exp_q[i][15:8]);
      if (i == abort_at) begin
        rst = 1'b0;
        start = 1'b0;
        dd = 1'b0;
        @(negedge clk);
        got = s ? obs_b : obs_a;
        cmp("abort_flags", i, got[7:0], 8'b1000_0000);
        cmp("abort_addr", i, got[15:8], 8'h00);
        rst = 1'b1;
        return;
      end
      start = (i < hold - 2) ? 1'b1 : 1'($urandom_range(0, 1));
      dd = (i == jdiv + d) ? 1'b1 : (i > jdiv && i < jdiv + d) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    dd = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    start = 1'b0;
    dd = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset_a_flags", 0, obs_a[7:0], 8'b1000_0000);
    cmp("reset_a_addr", 0, obs_a[15:8], 8'h00);
    cmp("reset_b_flags", 0, obs_b[7:0], 8'b1000_0000);
    cmp("reset_b_addr", 0, obs_b[15:8], 8'h00);
    rst = 1'b1;
    @(negedge clk);
    cmp("idle_a_flags", 0, obs_a[7:0], 8'b1000_0000);
    run(0, 3, 1, -1);
    run(0, 3, 10, -1);
    run(0, 2, 10, -1);
    run(0, 4, 1, 10);
    run(0, 3, 1, -1);
    run(0, 100, 1, -1);
    for (int r = 0; r < 4; r++) run(0, $urandom_range(1, 6), $urandom_range(1, 12), -1);
    run(1, $urandom_range(1, 5), 1, -1);
    repeat (2) @(negedge clk);
    cmp("final_b_flags", 0, obs_b[7:0], 8'b1000_0000);
    cmp("final_a_flags", 0, obs_a[7:0], 8'b1000_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
